// File: rtl/carfield_domain_seq.sv
// Carfield domain power/clock sequencer.
// One shared FSM walks a single domain through its clock/reset/isolation
// enable or disable sequence; every domain owns a programmable clock divider
// that runs independently of the others.

// Per-domain clock divider: emits one clock-enable pulse every 'active' cycles
// while the domain is clocking. A new divider value is staged in 'pending' and
// takes effect at the next wrap, or at once while the domain is stopped.
module carfield_domain_div #(
    parameter int DivWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run_i,
    input  logic                clr_i,
    input  logic                set_i,
    input  logic [DivWidth-1:0] div_i,
    output logic                clk_en_o
);
    localparam logic [DivWidth-1:0] One = DivWidth'(1);

    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] active_q, active_d;
    logic [DivWidth-1:0] pending_q, pending_d;
    logic                last;

    assign last     = (cnt_q >= (active_q - One));
    assign clk_en_o = run_i && (cnt_q == (active_q - One));

    // Counter advance, wrap and staged divider hand-over.
    always_comb begin
        pending_d = set_i ? div_i : pending_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        if (!run_i) begin
            cnt_d    = '0;
            active_d = pending_d;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (last) begin
            cnt_d    = '0;
            active_d = pending_q;
        end else begin
            cnt_d = cnt_q + One;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            active_q  <= One;
            pending_q <= One;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end
endmodule

module carfield_domain_seq #(
    parameter int NumDomains = 6,
    parameter int DivWidth   = 8,
    parameter int RstCycles  = 4,
    parameter int IsoCycles  = 2,
    localparam int DomW      = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [1:0]            cfg_op_i,
    input  logic [DomW-1:0]       cfg_dom_i,
    input  logic [DivWidth-1:0]   cfg_div_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [NumDomains-1:0] dom_clk_en_o,
    output logic [NumDomains-1:0] dom_rst_no,
    output logic [NumDomains-1:0] dom_iso_o,
    output logic [NumDomains-1:0] dom_on_o
);
    localparam int MaxCyc = (RstCycles > IsoCycles) ? RstCycles : IsoCycles;
    localparam int WaitW  = $clog2(MaxCyc + 1);
    localparam logic [WaitW-1:0] RstLd = WaitW'(RstCycles - 1);
    localparam logic [WaitW-1:0] IsoLd = WaitW'(IsoCycles - 1);

    typedef enum logic [2:0] {
        IDLE, PU_CLK, PU_REL, PD_ISO, PD_RST, DONE, ERR
    } state_e;

    state_e                state_q, state_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic [DomW-1:0]       dom_q, dom_d;
    logic [NumDomains-1:0] run_q, run_d;
    logic [NumDomains-1:0] rst_n_q, rst_n_d;
    logic [NumDomains-1:0] iso_q, iso_d;
    logic [NumDomains-1:0] on_q, on_d;
    logic [NumDomains-1:0] set_div;
    logic [NumDomains-1:0] clr_cnt;
    logic                  dom_ok;
    logic                  sel_on;

    assign dom_ok = (32'(cfg_dom_i) < NumDomains);
    assign sel_on = dom_ok ? on_q[cfg_dom_i] : 1'b0;

    assign cfg_ready_o = (state_q == IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);
    assign dom_rst_no  = rst_n_q;
    assign dom_iso_o   = iso_q;
    assign dom_on_o    = on_q;
    // Force the counter to zero on the last running cycle of a disable.
    assign clr_cnt     = run_q & ~run_d;

    // Command decode, sequence stepping and per-domain control updates.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        dom_d   = dom_q;
        run_d   = run_q;
        rst_n_d = rst_n_q;
        iso_d   = iso_q;
        on_d    = on_q;
        set_div = '0;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    dom_d   = cfg_dom_i;
                    state_d = ERR;
                    if (dom_ok) begin
                        case (cfg_op_i)
                            2'd0: if (!sel_on) begin
                                run_d[cfg_dom_i] = 1'b1;
                                wait_d  = RstLd;
                                state_d = PU_CLK;
                            end
                            2'd1: if (sel_on) begin
                                iso_d[cfg_dom_i] = 1'b1;
                                on_d[cfg_dom_i]  = 1'b0;
                                wait_d  = IsoLd;
                                state_d = PD_ISO;
                            end
                            2'd2: if (cfg_div_i != '0) begin
                                set_div[cfg_dom_i] = 1'b1;
                                state_d = DONE;
                            end
                            default: state_d = ERR;
                        endcase
                    end
                end
            end
            PU_CLK: begin
                if (wait_q == '0) begin
                    rst_n_d[dom_q] = 1'b1;
                    wait_d  = IsoLd;
                    state_d = PU_REL;
                end else wait_d = wait_q - 1'b1;
            end
            PU_REL: begin
                if (wait_q == '0) begin
                    iso_d[dom_q] = 1'b0;
                    on_d[dom_q]  = 1'b1;
                    state_d = DONE;
                end else wait_d = wait_q - 1'b1;
            end
            PD_ISO: begin
                if (wait_q == '0) begin
                    rst_n_d[dom_q] = 1'b0;
                    wait_d  = RstLd;
                    state_d = PD_RST;
                end else wait_d = wait_q - 1'b1;
            end
            PD_RST: begin
                if (wait_q == '0) begin
                    run_d[dom_q] = 1'b0;
                    state_d = DONE;
                end else wait_d = wait_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and per-domain control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wait_q  <= '0;
            dom_q   <= '0;
            run_q   <= '0;
            rst_n_q <= '0;
            iso_q   <= '1;
            on_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            dom_q   <= dom_d;
            run_q   <= run_d;
            rst_n_q <= rst_n_d;
            iso_q   <= iso_d;
            on_q    <= on_d;
        end
    end

    for (genvar g = 0; g < NumDomains; g++) begin : g_div
        carfield_domain_div #(.DivWidth(DivWidth)) u_div (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .run_i    (run_q[g]),
            .clr_i    (clr_cnt[g]),
            .set_i    (set_div[g]),
            .div_i    (cfg_div_i),
            .clk_en_o (dom_clk_en_o[g])
        );
    end
endmodule

// File: tb/tb_carfield_domain_seq.sv
// Scoreboard bench for carfield_domain_seq: stimulus pushes expected
// completions and per-cycle output probes; a monitor checks them.
module tb_carfield_domain_seq;
    localparam int ND = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready_o;
    logic [1:0]    cfg_op = '0;
    logic [2:0]    cfg_dom = '0;
    logic [7:0]    cfg_div = '0;
    logic          done_o, err_o;
    logic [ND-1:0] dom_clk_en_o, dom_rst_no, dom_iso_o, dom_on_o;

    carfield_domain_seq #(.NumDomains(ND), .DivWidth(8), .RstCycles(4), .IsoCycles(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready_o),
        .cfg_op_i(cfg_op), .cfg_dom_i(cfg_dom), .cfg_div_i(cfg_div),
        .done_o(done_o), .err_o(err_o), .dom_clk_en_o(dom_clk_en_o),
        .dom_rst_no(dom_rst_no), .dom_iso_o(dom_iso_o), .dom_on_o(dom_on_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // probe bits: {ready, clk_en, rst_n, iso, on}
    typedef struct { int cyc; int dom; logic [4:0] exp; logic [4:0] msk; } probe_t;
    typedef struct { logic err; int t0; int lat; } resp_t;

    probe_t pq[$];
    resp_t  rq[$];
    int n_cmp = 0;
    int n_bad = 0;

    probe_t     p;
    resp_t      r;
    logic [4:0] act;

    // Monitor: compares completions and scheduled output probes.
    always @(negedge clk) begin
        if (done_o || err_o) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected cyc=%0d done=%b err=%b (no pending command)", cyc, done_o, err_o);
            end else begin
                r = rq.pop_front();
                if (err_o !== r.err || done_o !== !r.err || (cyc - r.t0) != r.lat) begin
                    n_bad++;
                    $display("FAIL resp cyc=%0d got done=%b err=%b lat=%0d want err=%b lat=%0d",
                             cyc, done_o, err_o, cyc - r.t0, r.err, r.lat);
                end
            end
        end
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            n_cmp++;
            act = {cfg_ready_o, dom_clk_en_o[p.dom], dom_rst_no[p.dom], dom_iso_o[p.dom], dom_on_o[p.dom]};
            if (p.cyc < cyc || ((act ^ p.exp) & p.msk) !== 5'b0) begin
                n_bad++;
                $display("FAIL probe cyc=%0d (sched %0d) dom=%0d got %b want %b mask %b",
                         cyc, p.cyc, p.dom, act, p.exp, p.msk);
            end
        end
    end

    task automatic probe(input int c, input int d, input logic [4:0] e, input logic [4:0] m);
        probe_t x;
        x.cyc = c; x.dom = d; x.exp = e; x.msk = m;
        pq.push_back(x);
    endtask

    task automatic expect_resp(input logic e, input int t0, input int lat);
        resp_t x;
        x.err = e; x.t0 = t0; x.lat = lat;
        rq.push_back(x);
    endtask

    // Present one command; t0 is the accept cycle. Inputs are scrambled afterwards.
    task automatic issue(input logic [1:0] op, input logic [2:0] dom, input logic [7:0] div, output int t0);
        int k = 0;
        @(negedge clk);
        while (!cfg_ready_o && k < 50) begin @(negedge clk); k++; end
        if (!cfg_ready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout cyc=%0d ready=%b want 1", cyc, cfg_ready_o);
        end
        cfg_valid = 1'b1; cfg_op = op; cfg_dom = dom; cfg_div = div;
        t0 = cyc;
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_op = ~op; cfg_dom = ~dom; cfg_div = ~div;
    endtask

    task automatic drain();
        int k = 0;
        while ((rq.size() != 0 || pq.size() != 0) && k < 100) begin @(posedge clk); k++; end
        if (rq.size() != 0 || pq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout resp_left=%0d probes_left=%0d want 0", rq.size(), pq.size());
            rq.delete(); pq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic all_reset(input int c);
        for (int d = 0; d < ND; d++) probe(c, d, 5'b10010, 5'b11111);
    endtask

    // Full ENABLE trace for a domain whose divider is 1.
    task automatic enable_trace(input int t0, input int d);
        for (int i = 1; i <= 4; i++) probe(t0 + i, d, 5'b01010, 5'b11111);
        probe(t0 + 5, d, 5'b01110, 5'b11111);
        probe(t0 + 6, d, 5'b01110, 5'b11111);
        probe(t0 + 7, d, 5'b01101, 5'b11111);
        probe(t0 + 8, d, 5'b11101, 5'b11111);
        expect_resp(1'b0, t0, 7);
    endtask

    task automatic err_cmd(input logic [1:0] op, input logic [2:0] dom, input logic [7:0] div,
                           input int pd, input logic [3:0] st);
        int t0;
        issue(op, dom, div, t0);
        probe(t0 + 1, pd, {1'b0, st}, 5'b11111);
        probe(t0 + 2, pd, {1'b1, st}, 5'b11111);
        expect_resp(1'b1, t0, 1);
        drain();
    endtask

    logic [4:0] clk_pat;
    initial begin
        int t0;
        // reset state, during and after reset
        @(posedge clk); #1;
        all_reset(cyc);
        @(posedge clk); #1;
        rst_n = 1'b1;
        all_reset(cyc);
        drain();

        // ENABLE dom2 and dom4, inputs scrambled after accept
        issue(2'd0, 3'd2, 8'd0, t0);
        enable_trace(t0, 2);
        drain();
        issue(2'd0, 3'd4, 8'd0, t0);
        enable_trace(t0, 4);
        drain();

        // SETDIV dom2=3 while clocking; dom4 keeps a constant enable
        issue(2'd2, 3'd2, 8'd3, t0);
        for (int i = 1; i <= 7; i++) begin
            clk_pat = (i == 1 || i == 4 || i == 7) ? 5'b01000 : 5'b00000;
            probe(t0 + i, 2, ((i == 1) ? 5'b00101 : 5'b10101) | clk_pat, 5'b11111);
            probe(t0 + i, 4, 5'b01101, 5'b01111);
        end
        expect_resp(1'b0, t0, 1);
        drain();

        // DISABLE dom2 (divider phase unknown until it stops)
        issue(2'd1, 3'd2, 8'd0, t0);
        for (int i = 1; i <= 8; i++) begin
            if (i <= 2)      probe(t0 + i, 2, 5'b00110, 5'b10111);
            else if (i <= 6) probe(t0 + i, 2, 5'b00010, 5'b10111);
            else if (i == 7) probe(t0 + i, 2, 5'b00010, 5'b11111);
            else             probe(t0 + i, 2, 5'b10010, 5'b11111);
            probe(t0 + i, 4, 5'b01101, 5'b01111);
        end
        expect_resp(1'b0, t0, 7);
        drain();

        // rejections: state unchanged, ready back two cycles after accept
        err_cmd(2'd1, 3'd2, 8'd0, 2, 4'b0010);   // DISABLE on off domain
        err_cmd(2'd0, 3'd4, 8'd0, 4, 4'b1101);   // ENABLE on on domain
        err_cmd(2'd0, 3'd6, 8'd0, 0, 4'b0010);   // domain out of range
        err_cmd(2'd2, 3'd0, 8'd0, 0, 4'b0010);   // SETDIV with zero
        err_cmd(2'd3, 3'd0, 8'd5, 0, 4'b0010);   // reserved op

        // reset in the middle of an ENABLE (dom2 divider is 3 here)
        issue(2'd0, 3'd2, 8'd0, t0);
        probe(t0 + 1, 2, 5'b00010, 5'b10111);
        probe(t0 + 2, 2, 5'b00010, 5'b10111);
        all_reset(t0 + 3);
        all_reset(t0 + 4);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        drain();

        // ENABLE after reset completes normally with divider back at 1
        issue(2'd0, 3'd2, 8'd0, t0);
        enable_trace(t0, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
